// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit: sub-word and (with LSU_MISALIGN_EN) misaligned accesses as full-word bus cycles
// Optional feature macro: LSU_MISALIGN_EN (split misaligned accesses across two words; rejected otherwise)
module lsu #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_sign,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              busy,
    output logic              bus_re,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [3:0]        bus_byte_mask,
    output logic              bus_un_sign,
    input  logic [DATA_W-1:0] bus_rdata
);

    typedef enum logic [2:0] {IDLE, RD0, WR0, RD1, WR1, DONE} state_t;

    state_t            state, state_next;
    logic              we_q, sign_q, err_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rd0_q, resp_rdata_q;
    logic [1:0]        off;
    logic [3:0]        nmask;
    logic [2:0]        req_end;
    logic              req_mis, req_err;
    logic [DATA_W-1:0] word0, ld_word, ld_result;
    logic [DATA_W-1:0] d_lo;
    logic [3:0]        m_lo;

    function automatic logic [31:0] lanes(input logic [3:0] m);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = {8{m[i]}};
        return r;
    endfunction

    assign off     = addr_q[1:0];
    assign nmask   = (size_q == 2'd0) ? 4'b0001 : (size_q == 2'd1) ? 4'b0011 : 4'b1111;
    assign req_end = {1'b0, req_addr[1:0]} +
                     ((req_size == 2'd0) ? 3'd1 : (req_size == 2'd1) ? 3'd2 : 3'd4);
    assign req_mis = (req_end > 3'd4);
    assign word0   = (state == RD0) ? bus_rdata : rd0_q;

`ifdef LSU_MISALIGN_EN
    logic              mis_q;
    logic [DATA_W-1:0] rd1_q, word1, d_hi;
    logic [3:0]        m_hi;
    logic [7:0]        mask64;
    logic [63:0]       data64;

    assign req_err = (req_size == 2'd3);
    assign word1   = (state == RD1) ? bus_rdata : rd1_q;
    assign ld_word = 32'({word1, word0} >> {off, 3'b000});
    assign mask64  = {4'b0000, nmask} << off;
    assign data64  = {32'h0, wdata_q} << {off, 3'b000};
    assign {m_hi, m_lo} = mask64;
    assign {d_hi, d_lo} = data64;
`else
    assign req_err = (req_size == 2'd3) || req_mis;
    assign ld_word = word0 >> {off, 3'b000};
    assign m_lo    = nmask << off;
    assign d_lo    = wdata_q << {off, 3'b000};
`endif

    // Extension uses the top byte of the access, not bit 31 of the bus word
    always_comb begin
        ld_result = ld_word;
        case (size_q)
            2'd0: ld_result = {{24{sign_q & ld_word[7]}}, ld_word[7:0]};
            2'd1: ld_result = {{16{sign_q & ld_word[15]}}, ld_word[15:0]};
            default: ld_result = ld_word;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (req_valid) begin
                if (req_err)                                state_next = DONE;
                else if (req_we && req_size == 2'd2 && !req_mis) state_next = WR0;
                else                                        state_next = RD0;
            end
`ifdef LSU_MISALIGN_EN
            RD0:  state_next = we_q ? WR0 : (mis_q ? RD1 : DONE);
            WR0:  state_next = mis_q ? RD1 : DONE;
            RD1:  state_next = we_q ? WR1 : DONE;
            WR1:  state_next = DONE;
`else
            RD0:  state_next = we_q ? WR0 : DONE;
            WR0:  state_next = DONE;
`endif
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            we_q         <= 1'b0;
            sign_q       <= 1'b0;
            err_q        <= 1'b0;
            size_q       <= 2'd0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rd0_q        <= '0;
            resp_rdata_q <= '0;
`ifdef LSU_MISALIGN_EN
            mis_q        <= 1'b0;
            rd1_q        <= '0;
`endif
        end else begin
            state <= state_next;
            if (state == IDLE && req_valid) begin
                we_q    <= req_we;
                sign_q  <= req_sign;
                err_q   <= req_err;
                size_q  <= req_size;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
`ifdef LSU_MISALIGN_EN
                mis_q   <= req_mis;
`endif
            end
            if (state == RD0) rd0_q <= bus_rdata;
`ifdef LSU_MISALIGN_EN
            if (state == RD1) rd1_q <= bus_rdata;
`endif
            if (state_next == DONE && state != DONE)
                resp_rdata_q <= (state == IDLE || we_q) ? '0 : ld_result;
        end
    end

    always_comb begin
        bus_re    = 1'b0;
        bus_we    = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        case (state)
            RD0: begin
                bus_re   = 1'b1;
                bus_addr = {addr_q[ADDR_W-1:2], 2'b00};
            end
            WR0: begin
                bus_we    = 1'b1;
                bus_addr  = {addr_q[ADDR_W-1:2], 2'b00};
                bus_wdata = (rd0_q & ~lanes(m_lo)) | (d_lo & lanes(m_lo));
            end
`ifdef LSU_MISALIGN_EN
            RD1: begin
                bus_re   = 1'b1;
                bus_addr = {addr_q[ADDR_W-1:2] + (ADDR_W-2)'(1), 2'b00};
            end
            WR1: begin
                bus_we    = 1'b1;
                bus_addr  = {addr_q[ADDR_W-1:2] + (ADDR_W-2)'(1), 2'b00};
                bus_wdata = (rd1_q & ~lanes(m_hi)) | (d_hi & lanes(m_hi));
            end
`endif
            default: ;
        endcase
    end

    assign bus_byte_mask = (bus_re || bus_we) ? 4'b1111 : 4'b0000;
    assign bus_un_sign   = 1'b0;
    assign req_ready     = (state == IDLE);
    assign busy          = (state != IDLE);
    assign resp_valid    = (state == DONE);
    assign resp_err      = (state == DONE) && err_q;
    assign resp_rdata    = resp_rdata_q;

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - directed-vector bench for lsu against a word memory model
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_sign = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid, resp_err, busy;
    logic [31:0] resp_rdata;
    logic        bus_re, bus_we, bus_un_sign;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_byte_mask;

    logic [31:0] mem [0:1023];
    int          vectors = 0;
    int          miscompares = 0;
    int          lat, n_re, n_we, n_resp;
    logic [31:0] r_data, re_addr0;
    logic        r_err;

    always #5 clk = ~clk;

    lsu #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_sign(req_sign), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
        .resp_rdata(resp_rdata), .busy(busy), .bus_re(bus_re), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_byte_mask(bus_byte_mask),
        .bus_un_sign(bus_un_sign), .bus_rdata(bus_rdata)
    );

    assign bus_rdata = mem[bus_addr[11:2]];

    always @(posedge clk) if (bus_we) mem[bus_addr[11:2]] <= bus_wdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_req(input logic we, input logic [1:0] size, input logic sign,
                          input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_sign = sign;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0; req_addr = '0; req_wdata = '0;
        lat = -1; n_re = 0; n_we = 0; r_data = 'x; r_err = 1'bx; re_addr0 = '0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (bus_re) begin
                if (n_re == 0) re_addr0 = bus_addr;
                n_re++;
            end
            if (bus_we) n_we++;
            if (resp_valid) begin
                lat = c; r_data = resp_rdata; r_err = resp_err;
                break;
            end
        end
        if (lat < 0) check("resp_timeout", 32'(lat), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", {31'b0, req_ready}, 32'd1);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_resp_err", {31'b0, resp_err}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_bus_strobes", {28'b0, bus_re, bus_we, bus_un_sign, 1'b0}, 32'd0);
        check("rst_bus_addr", bus_addr, 32'h0);
        check("rst_bus_mask", {28'b0, bus_byte_mask}, 32'd0);
        rst = 1'b0;

        mem[32'h100 >> 2] = 32'hDEADBEEF;
        do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
        check("wload_lat", 32'(lat), 32'd2);
        check("wload_data", r_data, 32'hDEADBEEF);
        check("wload_nre", 32'(n_re), 32'd1);
        check("wload_addr", re_addr0, 32'h100);
        check("wload_err", {31'b0, r_err}, 32'd0);

        mem[32'h100 >> 2] = 32'h80AABBCC;
        do_req(1'b0, 2'd0, 1'b1, 32'h103, 32'h0);
        check("bload_signed", r_data, 32'hFFFFFF80);
        do_req(1'b0, 2'd0, 1'b0, 32'h103, 32'h0);
        check("bload_unsigned", r_data, 32'h00000080);

        mem[32'h200 >> 2] = 32'hAAAAAAAA;
        do_req(1'b1, 2'd1, 1'b0, 32'h202, 32'h00001234);
        check("hstore_lat", 32'(lat), 32'd3);
        check("hstore_mem", mem[32'h200 >> 2], 32'h1234AAAA);
        check("hstore_cycles", 32'(n_re * 16 + n_we), 32'h11);
        check("hstore_rdata", r_data, 32'h0);

        mem[32'h200 >> 2] = 32'h80010000;
        do_req(1'b0, 2'd1, 1'b1, 32'h202, 32'h0);
        check("hload_signed", r_data, 32'hFFFF8001);

        mem[32'h240 >> 2] = 32'h11223344;
        do_req(1'b1, 2'd0, 1'b0, 32'h241, 32'hFFFFFF55);
        check("bstore_mem", mem[32'h240 >> 2], 32'h11225544);

        do_req(1'b1, 2'd2, 1'b0, 32'h500, 32'hCAFEF00D);
        check("wstore_lat", 32'(lat), 32'd2);
        check("wstore_nre", 32'(n_re), 32'd0);
        check("wstore_mem", mem[32'h500 >> 2], 32'hCAFEF00D);

        do_req(1'b0, 2'd3, 1'b0, 32'h100, 32'h0);
        check("illegal_lat", 32'(lat), 32'd1);
        check("illegal_err", {31'b0, r_err}, 32'd1);
        check("illegal_bus", 32'(n_re + n_we), 32'd0);

        mem[32'h300 >> 2] = 32'h33221100;
        mem[32'h304 >> 2] = 32'h77665544;
        do_req(1'b0, 2'd2, 1'b0, 32'h301, 32'h0);
`ifdef LSU_MISALIGN_EN
        check("misload_lat", 32'(lat), 32'd3);
        check("misload_data", r_data, 32'h44332211);
        check("misload_nre", 32'(n_re), 32'd2);
`else
        check("misload_lat", 32'(lat), 32'd1);
        check("misload_err", {31'b0, r_err}, 32'd1);
        check("misload_nre", 32'(n_re), 32'd0);
        check("misload_rdata", r_data, 32'h0);
`endif

        do_req(1'b1, 2'd2, 1'b0, 32'h403, 32'hDDCCBBAA);
`ifdef LSU_MISALIGN_EN
        check("misstore_lat", 32'(lat), 32'd5);
        check("misstore_cycles", 32'(n_re + n_we), 32'd4);
        check("misstore_w0", mem[32'h400 >> 2], 32'hAA000000);
        check("misstore_w1", mem[32'h404 >> 2], 32'h00DDCCBB);
`else
        check("misstore_lat", 32'(lat), 32'd1);
        check("misstore_err", {31'b0, r_err}, 32'd1);
        check("misstore_w0", mem[32'h400 >> 2], 32'h0);
        check("misstore_w1", mem[32'h404 >> 2], 32'h0);
`endif

        // Abort mid-read: RD1 of a split load when enabled, else RD0 of an aligned load
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2;
`ifdef LSU_MISALIGN_EN
        req_addr = 32'h301;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
`else
        req_addr = 32'h300;
        @(posedge clk);
`endif
        #1 req_valid = 1'b0;
        check("abort_pre_re", {31'b0, bus_re}, 32'd1);
        rst = 1'b1;
        #1;
        check("abort_re_drop", {31'b0, bus_re}, 32'd0);
        n_resp = 0;
        repeat (2) @(negedge clk) if (resp_valid) n_resp++;
        rst = 1'b0;
        check("abort_ready", {31'b0, req_ready}, 32'd1);
        repeat (5) @(negedge clk) if (resp_valid) n_resp++;
        check("abort_no_resp", 32'(n_resp), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit between the execute stage and master port 0 of the system bus arbiter. It accepts one byte, halfword or word load/store at a time and converts it into full-word, word-aligned bus accesses. Sub-word stores become read-modify-write sequences, and misaligned accesses are split across two words. It then returns the assembled and extended load result to execute with a valid pulse.

## Interface

Parameters:
- ADDR_W, 32, byte address width
- DATA_W, 32, data width; fixed at 32, other values unsupported

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  high when the unit can accept a request; equals (state == IDLE)
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_sign  in  1  load sign-extends when 1, zero-extends when 0
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  qualifies resp_valid: request rejected, no bus traffic issued
- resp_rdata  out  32  load result; 0 for stores and errors
- busy  out  1  state != IDLE
- bus_re  out  1  word read to arbiter m0
- bus_we  out  1  word write to arbiter m0
- bus_addr  out  32  word-aligned address, {addr[31:2], 2'b00}
- bus_wdata  out  32  merged write word
- bus_byte_mask  out  4  4'b1111 while bus_re or bus_we is high, else 0
- bus_un_sign  out  1  tied 0; the LSU does all extension itself
- bus_rdata  in  32  arbiter read data, combinational in the same cycle as bus_re

## Operation

- Accept on req_valid && req_ready at a rising edge. The request is registered; inputs are don't-care afterwards.
- Byte count n = 1/2/4. Byte i of the access maps to word (A+i)>>2, lane (A+i)&3, little-endian.
- An access is misaligned when A[1:0] + n > 4.
- States:
  - IDLE
  - RD0: read word 0
  - WR0: write word 0
  - RD1: read word 1 at word 0 + 4
  - WR1: write word 1
  - DONE
- Load path:
  - Aligned: IDLE → RD0 → DONE.
  - Misaligned: IDLE → RD0 → RD1 → DONE.
  - Read data is captured at the end of each RD state.
- Store path:
  - Word store with A[1:0] = 0: IDLE → WR0 → DONE. bus_wdata = req_wdata.
  - Other non-misaligned stores: IDLE → RD0 → WR0 → DONE.
  - Misaligned stores: IDLE → RD0 → WR0 → RD1 → WR1 → DONE.
  - In each WR state, lanes covered by the access take req_wdata bytes; all other lanes keep the captured read word.
- Illegal size (11): IDLE → DONE with resp_err = 1 and no bus cycle.
- Load result: the n bytes are assembled into the low bits. Upper bits are filled with the top byte's bit 7 when req_sign = 1, else zeros. Word loads ignore req_sign.
- DONE: resp_valid = 1 for one cycle, then return to IDLE. resp_rdata is valid only while resp_valid is high and is held otherwise.
- Bus outputs are registered-state decodes. Outside RD/WR states, bus_re/bus_we/bus_byte_mask are 0.
- The arbiter gives m0 absolute priority, so there is no bus wait state.

## Timing

- Cycle 0 is the accept cycle. Responses arrive as follows:
  - Aligned load: resp_valid in cycle 2.
  - Misaligned load: cycle 3.
  - Aligned word store: cycle 2.
  - Sub-word store: cycle 3.
  - Misaligned store: cycle 5.
  - Illegal size: cycle 1.
- Throughput: the next accept is possible in the cycle after DONE.
- Reset values: state IDLE, req_ready = 1, busy = 0, resp_valid = 0, resp_err = 0, resp_rdata = 0, all bus_* = 0.
- Reset mid-operation: the FSM goes to IDLE immediately (asynchronous), bus strobes drop in the same cycle, and no resp_valid is produced for the aborted request. A partially completed misaligned store is not rolled back.
- req_valid while busy is ignored; it is not queued.

## Configuration

- LSU_MISALIGN_EN defined: misaligned accesses are split as described above.
- LSU_MISALIGN_EN undefined: a misaligned request goes IDLE → DONE with resp_err = 1 and resp_rdata = 0. No bus access is issued. RD1/WR1 and word-1 datapath logic are not synthesized.

## Test plan

- Word load at 0x100, mem[0x100] = 0xDEADBEEF → one bus_re at 0x100 in cycle 1; resp_valid in cycle 2 with 0xDEADBEEF.
- Byte load at 0x103, mem = 0x80AABBCC: with req_sign = 1 → 0xFFFFFF80; with req_sign = 0 → 0x00000080.
- Halfword store 0x1234 at 0x202, mem[0x200] = 0xAAAAAAAA → read in cycle 1, write of 0x1234AAAA in cycle 2, resp_valid in cycle 3.
- Word load at 0x301, mem[0x300] = 0x33221100, mem[0x304] = 0x77665544:
  - With LSU_MISALIGN_EN → 0x44332211 in cycle 3.
  - Without it → resp_err in cycle 1 and no bus_re.
- Word store 0xDDCCBBAA at 0x403, both words initially 0, with LSU_MISALIGN_EN → mem[0x400] = 0xAA000000 and mem[0x404] = 0x00DDCCBB; four bus cycles; resp_valid in cycle 5.
- Assert rst during RD1 of a misaligned load → bus_re low in the same cycle; after release req_ready = 1; no resp_valid observed.
